// File: rtl/mac_rx_frame_writer_pkg.sv
// Shared state encoding, header layout and default sizing for the MAC receive frame writer.
package mac_rx_frame_writer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    COMMIT = 2'd2,
    DROP   = 2'd3
  } rx_state_t;

  localparam int BYTE_CNT_MSB        = 63;
  localparam int BYTE_CNT_LSB        = 32;
  localparam int DEF_AW              = 10;
  localparam int DEF_FILL_LIMIT      = 922;
  localparam int DEF_MAX_FRAME_WORDS = 1200;

  // Legal non-empty byte enables fill contiguously from bit 0.
  function automatic logic is_thermo(input logic [7:0] v);
    return (v != 8'h00) && ((v & (v + 8'h01)) == 8'h00);
  endfunction

  function automatic logic [3:0] byte_count(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/mac_rx_rdptr_sync.sv
// Brings the host read pointer into the MAC clock: 2-flop strobe synchroniser plus gated capture.
module mac_rx_rdptr_sync
  import mac_rx_frame_writer_pkg::*;
#(
  parameter int AW = DEF_AW
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_addr_change,
  input  logic [AW:0] rd_addr_extended,
  output logic [AW:0] rd_ptr
);

  logic        chg_s1;
  logic        chg_s2;
  logic [AW:0] ptr_q;

  // The pointer bus is only trusted once the strobe has crossed, so it is sampled when chg_s2 is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      chg_s1 <= 1'b0;
      chg_s2 <= 1'b0;
      ptr_q  <= '0;
      rd_ptr <= '0;
    end else begin
      chg_s1 <= rd_addr_change;
      chg_s2 <= chg_s1;
      ptr_q  <= rd_addr_extended;
      if (chg_s2) rd_ptr <= ptr_q;
    end
  end

endmodule

// File: rtl/mac_rx_frame_writer.sv
// MAC receive frame writer: stores frames in a circular buffer, then a {byte_cnt, ts} header at the first slot.
// Define MAC_RX_TIMESTAMP_EN to fill header bits [31:0] with a free-running SOF cycle timestamp.
module mac_rx_frame_writer
  import mac_rx_frame_writer_pkg::*;
#(
  parameter int AW              = DEF_AW,
  parameter int FILL_LIMIT      = DEF_FILL_LIMIT,
  parameter int MAX_FRAME_WORDS = DEF_MAX_FRAME_WORDS
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [63:0]   rx_data,
  input  logic [7:0]    rx_data_valid,
  input  logic          rx_good_frame,
  input  logic          rx_bad_frame,
  output logic [AW-1:0] wr_addr,
  output logic [63:0]   wr_data,
  output logic          wr_en,
  output logic [AW:0]   commited_wr_address,
  input  logic          rd_addr_change,
  input  logic [AW:0]   rd_addr_extended,
  output logic [31:0]   rx_frames_counter,
  output logic [31:0]   dropped_frames_counter,
  output logic [31:0]   bad_frames_counter
);

  // state  | meaning
  // IDLE   | waiting for a preamble word
  // DATA   | storing frame words at aux_ptr
  // COMMIT | writing header at start_ptr, publishing the new commit pointer
  // DROP   | discarding the rest of a rejected frame until EOF

  localparam int          WCW       = $clog2(MAX_FRAME_WORDS + 1);
  localparam logic [AW:0] PTR_ONE   = (AW + 1)'(1);
  localparam logic [AW:0] FILL_LIM  = (AW + 1)'(FILL_LIMIT);
  localparam logic [WCW-1:0] MAX_WORDS = WCW'(MAX_FRAME_WORDS);

  rx_state_t      state;
  logic [AW:0]    start_ptr;
  logic [AW:0]    aux_ptr;
  logic [AW:0]    rd_ptr;
  logic [AW:0]    used;
  logic [31:0]    byte_cnt;
  logic [WCW-1:0] word_cnt;
  logic [31:0]    ts;
  logic [31:0]    ts_now;
  logic           vld;
  logic           thermo;

  mac_rx_rdptr_sync #(.AW(AW)) u_rdptr_sync (
    .clk              (clk),
    .reset            (reset),
    .rd_addr_change   (rd_addr_change),
    .rd_addr_extended (rd_addr_extended),
    .rd_ptr           (rd_ptr)
  );

`ifdef MAC_RX_TIMESTAMP_EN
  logic [31:0] cycle_cnt;

  always_ff @(posedge clk) begin
    if (reset) cycle_cnt <= '0;
    else       cycle_cnt <= cycle_cnt + 32'd1;
  end

  assign ts_now = cycle_cnt;
`else
  assign ts_now = 32'd0;
`endif

  assign used                = aux_ptr - rd_ptr;
  assign vld                 = (rx_data_valid != 8'h00);
  assign thermo              = is_thermo(rx_data_valid);
  assign commited_wr_address = start_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state                  <= IDLE;
      start_ptr              <= '0;
      aux_ptr                <= '0;
      byte_cnt               <= '0;
      word_cnt               <= '0;
      ts                     <= '0;
      wr_en                  <= 1'b0;
      wr_addr                <= '0;
      wr_data                <= '0;
      rx_frames_counter      <= '0;
      dropped_frames_counter <= '0;
      bad_frames_counter     <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          aux_ptr  <= start_ptr + PTR_ONE;
          byte_cnt <= '0;
          word_cnt <= '0;
          if (vld) begin
            ts    <= ts_now;
            state <= DATA;
          end
        end

        DATA: begin
          if (rx_bad_frame) begin
            bad_frames_counter <= bad_frames_counter + 32'd1;
            state              <= IDLE;
          end else if (vld && !thermo) begin
            bad_frames_counter <= bad_frames_counter + 32'd1;
            state              <= rx_good_frame ? IDLE : DROP;
          end else if (vld && (used >= FILL_LIM)) begin
            dropped_frames_counter <= dropped_frames_counter + 32'd1;
            state                  <= rx_good_frame ? IDLE : DROP;
          end else if (vld && (word_cnt == MAX_WORDS)) begin
            bad_frames_counter <= bad_frames_counter + 32'd1;
            state              <= rx_good_frame ? IDLE : DROP;
          end else begin
            if (vld) begin
              wr_en    <= 1'b1;
              wr_addr  <= aux_ptr[AW-1:0];
              wr_data  <= rx_data;
              aux_ptr  <= aux_ptr + PTR_ONE;
              word_cnt <= word_cnt + WCW'(1);
              byte_cnt <= byte_cnt + {28'd0, byte_count(rx_data_valid)};
            end
            if (rx_good_frame) state <= COMMIT;
          end
        end

        COMMIT: begin
          wr_en                               <= 1'b1;
          wr_addr                             <= start_ptr[AW-1:0];
          wr_data[BYTE_CNT_MSB:BYTE_CNT_LSB]  <= byte_cnt;
          wr_data[BYTE_CNT_LSB-1:0]           <= ts;
          start_ptr                           <= aux_ptr;
          aux_ptr                             <= aux_ptr + PTR_ONE;
          byte_cnt                            <= '0;
          word_cnt                            <= '0;
          rx_frames_counter                   <= rx_frames_counter + 32'd1;
          // A valid word here is already the next frame's preamble.
          if (vld) begin
            ts    <= ts_now;
            state <= DATA;
          end else begin
            state <= IDLE;
          end
        end

        DROP: begin
          if (rx_good_frame || rx_bad_frame) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mac_rx_frame_writer.md
Name: mac_rx_frame_writer

Overview:
- Parametrised next-generation MAC receive front end, on the 156.25 MHz MAC clock.
- Strips the preamble word, writes 64-bit frame words into a circular on-chip buffer, then writes a header word (byte count + SOF timestamp) at the frame's first slot.
- Publishes a committed write pointer to the host-side DMA logic.
- Adds oversize and malformed-frame rejection, a programmable fill threshold and per-reason statistics counters.

Parameters:
- AW, 10, buffer address width in 64-bit words; buffer depth = 2**AW.
- FILL_LIMIT, 922, drop threshold in words of occupancy; must be < 2**AW.
- MAX_FRAME_WORDS, 1200, maximum stored data words per frame (excludes header).

Ports:
- clk  in  1  MAC clock.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  64  MAC receive data.
- rx_data_valid  in  8  byte enables; legal values are 0x00 or thermometer codes from bit 0.
- rx_good_frame  in  1  end of frame, frame good.
- rx_bad_frame  in  1  end of frame, frame bad.
- wr_addr  out  AW  buffer write address.
- wr_data  out  64  buffer write data.
- wr_en  out  1  buffer write strobe.
- commited_wr_address  out  AW+1  extended pointer one past the last committed word.
- rd_addr_change  in  1  host-side read-pointer update strobe (foreign domain).
- rd_addr_extended  in  AW+1  host-side extended read pointer (foreign domain).
- rx_frames_counter  out  32  committed frames.
- dropped_frames_counter  out  32  frames dropped for buffer fill.
- bad_frames_counter  out  32  bad, malformed or oversize frames.

Behaviour:
- Reset (reset=1 at a clk edge): state IDLE; wr_en=0; wr_addr=0; wr_data=0; commited_wr_address=0; all counters=0; synchronised read pointer=0. A partial frame in flight is discarded.
- Read-pointer sync: rd_addr_change passes through a 2-flop synchroniser; rd_addr_extended is registered once. The synchronised pointer rd_ptr is loaded from that register only while the synchronised strobe is high.
- Internal pointers: start_ptr (extended, equals commited_wr_address), aux_ptr (next data slot), byte_cnt[31:0], word_cnt.
- Occupancy: used = (aux_ptr - rd_ptr) mod 2**(AW+1), combinational.
- All outputs are registered; a buffer write appears on wr_* one cycle after the rx_* inputs that cause it.
- IDLE:
  - aux_ptr <= start_ptr+1; byte_cnt, word_cnt <= 0; wr_en <= 0.
  - rx_data_valid != 0 marks the preamble word. It is not stored; capture the timestamp and go to DATA.
- DATA, evaluated in this priority order:
  - rx_bad_frame, or rx_bad_frame together with rx_good_frame: bad_frames_counter++ -> IDLE. No commit; the current word is not written.
  - Non-thermometer, non-zero rx_data_valid: bad_frames_counter++ -> DROP (IDLE if EOF is in the same cycle).
  - Valid word with used >= FILL_LIMIT: dropped_frames_counter++ -> DROP (IDLE if EOF is in the same cycle).
  - Valid word with word_cnt == MAX_FRAME_WORDS: bad_frames_counter++ -> DROP.
  - Otherwise, for a valid word: write rx_data at aux_ptr[AW-1:0]; aux_ptr++, word_cnt++; byte_cnt += popcount(rx_data_valid).
  - If rx_good_frame is high and no drop occurred: -> COMMIT. The word in that cycle is written if valid; a zero-data good frame is still committed.
- COMMIT:
  - Write {byte_cnt, ts} at start_ptr[AW-1:0].
  - start_ptr <= aux_ptr; aux_ptr <= aux_ptr+1; rx_frames_counter++.
  - rx_data_valid != 0 in this cycle is the next frame's preamble -> DATA, timestamp captured; otherwise -> IDLE.
- DROP:
  - wr_en=0; wait for rx_good_frame or rx_bad_frame -> IDLE.
  - commited_wr_address is unchanged, so partial words are overwritten by the next frame.
- Wrap-around: all extended pointers wrap modulo 2**(AW+1); buffer addresses use the low AW bits.
- Counters wrap at 2**32.

Optional Feature:
- Macro MAC_RX_TIMESTAMP_EN.
- Defined: a free-running 32-bit cycle counter (reset 0, +1 per clk) is sampled on the preamble cycle into ts, which fills header bits [31:0].
- Undefined: no counter is built; header bits [31:0] = 0.

Decomposition:
- Shared include (includes.v): state encodings IDLE/DATA/COMMIT/DROP, header field offsets (BYTE_CNT_MSB=63, BYTE_CNT_LSB=32), default AW/FILL_LIMIT.
- One sub-module: mac_rx_rdptr_sync, parameter AW. It holds the 2-flop strobe synchroniser and the gated pointer capture.

Test Plan:
- Frame 1: preamble, 8 words of 0xFF, 1 word of 0x0F with rx_good_frame. Data at addresses 1..9; header {32'd68, ts} at 0; commited_wr_address=10; rx_frames_counter=1.
- Back-to-back: preamble of frame 2 arrives in the COMMIT cycle of frame 1. Frame 2 header lands at 10; no word is lost; counter=2.
- rd_ptr held at 0, 1-word frames streamed: the frame that reaches used>=922 is dropped; dropped_frames_counter=1; commited_wr_address unchanged; an rd_addr_change to 900 resumes commits.
- rx_data_valid=0x05 mid-frame: bad_frames_counter=1; no commit. 1201-word frame: bad_frames_counter increments; pointer unchanged.
- Pointer wrap with AW=4 over 40 frames: addresses wrap modulo 16; the header always sits at the old commited_wr_address[3:0]. reset asserted mid-frame: all outputs 0 on the next cycle.
